dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Load/store sequencer between the execute stage and the data-memory port. It accepts one load or store per transaction and performs the memory request/grant/rvalid handshake. Stores get byte-lane replication and byte enables; load data is lane-selected and sign- or zero-extended. Misaligned accesses, illegal funct3 values and memory timeouts are reported as errors.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waited for grant or rvalid before an error response; legal range 2..255
CNT_W, 8, width of the timeout counter

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  pipeline request valid
o_req_ready  out  1  controller can accept a request
i_is_store  in  1  1 = store, 0 = load
iv_funct3  in  3  instruction bits 14:12
iv_addr  in  32  byte address
iv_wdata  in  32  store source data, right-aligned
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_err  out  1  qualifies o_rsp_valid: misalign, illegal funct3 or timeout
ov_rdata  out  32  extended load data; 0 for stores and errors
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepted the request
ov_mem_addr  out  32  word address: {addr[31:2],2'b00}
o_mem_we  out  1  write enable
ov_mem_be  out  4  byte enables
ov_mem_wdata  out  32  lane-replicated write data
i_mem_rvalid  in  1  read data valid
iv_mem_rdata  in  32  read data word

Behaviour:
- Reset values: every output is 0, FSM is IDLE, counter is 0. Reset is asynchronous, so asserting it mid-transaction drops o_mem_req immediately and discards the transaction.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: latch is_store, funct3, addr and wdata, then decode.
  - Illegal or misaligned request → RESP with error; no memory access.
  - Otherwise → REQ.
- Legal funct3:
  - Load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Store: 000 sb, 001 sh, 010 sw.
- Misaligned: h with addr[0]=1; w with addr[1:0]!=0.
- REQ:
  - o_mem_req=1; address, we, be and wdata stay stable until grant.
  - i_mem_gnt: store → RESP ok; load → WAIT_R.
  - i_mem_rvalid while in REQ is ignored.
- WAIT_R:
  - o_mem_req=0.
  - i_mem_rvalid: capture the extended data → RESP ok.
- Timeout:
  - The counter clears on entry to REQ and to WAIT_R, and increments each cycle spent in either state.
  - When the counter reaches TIMEOUT_CYCLES-1 with no gnt or rvalid → RESP with err.
  - If gnt or rvalid arrives on that same cycle, it wins.
- RESP:
  - o_rsp_valid=1 for exactly one cycle, with o_rsp_err and ov_rdata valid in that cycle.
  - Next state is IDLE; o_req_ready=0.
- Store lanes:
  - sb: wdata={4{b[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: wdata={2{h[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - sw: wdata unchanged, be=4'b1111.
  - Loads drive we=0, be=4'b1111.
- Load extract:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Latency with no wait states:
  - Store: accept at cycle 0, REQ+gnt at cycle 1, rsp at cycle 2.
  - Load: accept at cycle 0, REQ+gnt at cycle 1, rvalid at cycle 2, rsp at cycle 3.
- Only one transaction is in flight at a time; no pipelining.

Decomposition:
- Shared package:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (2 bits).
  - Byte-enable constants.
- Sub-module dmem_lane_fmt: pure combinational store replication/byte-enable and load extract/extension. It supersedes the standalone store-width formatting logic.

Test Plan:
- sb, addr=0x1003, wdata=0x000000A5, gnt at first REQ cycle → mem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, rsp at cycle 2, err=0.
- lb, addr=0x2001, rdata=0x12348056 on rvalid → ov_rdata=0xFFFFFF80; repeat as lbu → 0x00000080; lhu at 0x2002 → 0x00001234.
- lw, addr=0x3002 → no o_mem_req ever; rsp_valid+err at cycle 1, rdata=0; store funct3=011 → same error behaviour.
- Store with gnt withheld 5 cycles → o_mem_req and mem outputs stable 5 cycles, completion 1 cycle after gnt; gnt withheld ≥TIMEOUT_CYCLES → err rsp, o_mem_req drops.
- Load with gnt then i_rst_n pulsed low in WAIT_R → all outputs 0 asynchronously; late rvalid after reset ignored; next lw at 0x4000 completes with correct data.
- Back-to-back: i_req_valid held high for two requests → second accepted only after RESP→IDLE; o_req_ready low throughout REQ, WAIT_R and RESP.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: funct3 codes,
// FSM state encoding, byte-enable patterns and request decode helpers.
package dmem_access_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_LO_H = 4'b0011;
   localparam logic [3:0] BE_HI_H = 4'b1100;
   localparam logic [3:0] BE_ALL  = 4'b1111;

   // Stores only know sb/sh/sw; loads additionally have the unsigned forms.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (is_store) begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      end else begin
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

   // Access size lives in funct3[1:0]: 01 = half, 10 = word.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (f3[1:0])
         2'b01:   bad = addr_lo[0];
         2'b10:   bad = (addr_lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store replication and byte enables, plus load lane
// selection with sign or zero extension. Purely combinational.
module dmem_lane_fmt
   import dmem_access_ctrl_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic signed [7:0]  byte_sel;
   logic signed [15:0] half_sel;

   // Store side: replicate the source across all lanes it may land in.
   always_comb begin
      be        = BE_ALL;
      wdata_rep = '0;
      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               wdata_rep = {4{wdata[7:0]}};
               be        = BE_B0 << addr_lo;
            end
            2'b01: begin
               wdata_rep = {2{wdata[15:0]}};
               be        = addr_lo[1] ? BE_HI_H : BE_LO_H;
            end
            default: begin
               wdata_rep = wdata;
               be        = BE_ALL;
            end
         endcase
      end
   end

   // Load side: pick the addressed lane, then extend according to funct3.
   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
         F3_BU:   rdata_ext = {24'b0, byte_sel};
         F3_HU:   rdata_ext = {16'b0, half_sel};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer: accepts one access at a time, runs the memory
// req/gnt/rvalid handshake with a timeout, and returns a one-cycle response.
module dmem_access_ctrl
   import dmem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
)
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_is_store,
   input  logic [2:0]  iv_funct3,
   input  logic [31:0] iv_addr,
   input  logic [31:0] iv_wdata,
   output logic        o_rsp_valid,
   output logic        o_rsp_err,
   output logic [31:0] ov_rdata,
   output logic        o_mem_req,
   input  logic        i_mem_gnt,
   output logic [31:0] ov_mem_addr,
   output logic        o_mem_we,
   output logic [3:0]  ov_mem_be,
   output logic [31:0] ov_mem_wdata,
   input  logic        i_mem_rvalid,
   input  logic [31:0] iv_mem_rdata
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              ready_q;
   logic              is_store_q;
   logic [2:0]        f3_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic              accept;
   logic              bad_req;
   logic              cnt_done;
   logic [3:0]        be_fmt;
   logic [31:0]       wdata_fmt;
   logic [31:0]       rdata_fmt;

   assign accept   = (state_q == ST_IDLE) && ready_q && i_req_valid;
   assign bad_req  = !f3_legal(i_is_store, iv_funct3) || misaligned(iv_funct3, iv_addr[1:0]);
   assign cnt_done = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   dmem_lane_fmt u_lane_fmt (
      .is_store  (is_store_q),
      .funct3    (f3_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (iv_mem_rdata),
      .be        (be_fmt),
      .wdata_rep (wdata_fmt),
      .rdata_ext (rdata_fmt)
   );

   // Next state and outputs; memory and response outputs are zero outside their states.
   always_comb begin
      state_d      = state_q;
      o_req_ready  = ready_q;
      o_mem_req    = 1'b0;
      ov_mem_addr  = '0;
      o_mem_we     = 1'b0;
      ov_mem_be    = BE_NONE;
      ov_mem_wdata = '0;
      o_rsp_valid  = 1'b0;
      o_rsp_err    = 1'b0;
      ov_rdata     = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = bad_req ? ST_RESP : ST_REQ;
         end
         ST_REQ: begin
            o_mem_req    = 1'b1;
            ov_mem_addr  = {addr_q[31:2], 2'b00};
            o_mem_we     = is_store_q;
            ov_mem_be    = be_fmt;
            ov_mem_wdata = is_store_q ? wdata_fmt : '0;
            if (i_mem_gnt)     state_d = is_store_q ? ST_RESP : ST_WAIT_R;
            else if (cnt_done) state_d = ST_RESP;
         end
         ST_WAIT_R: begin
            if (i_mem_rvalid || cnt_done) state_d = ST_RESP;
         end
         ST_RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = err_q;
            ov_rdata    = rdata_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state: FSM, timeout counter and the registered ready flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         if ((state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_WAIT_R)))
            cnt_q <= '0;
         else if ((state_q == ST_REQ) || (state_q == ST_WAIT_R))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Transaction data: captured at accept, result filled in as the access completes.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         is_store_q <= i_is_store;
         f3_q       <= iv_funct3;
         addr_q     <= iv_addr;
         wdata_q    <= iv_wdata;
         err_q      <= bad_req;
         rdata_q    <= '0;
      end else if (state_q == ST_REQ) begin
         if (!i_mem_gnt && cnt_done) err_q <= 1'b1;
      end else if (state_q == ST_WAIT_R) begin
         if (i_mem_rvalid)  rdata_q <= rdata_fmt;
         else if (cnt_done) err_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a scripted memory responder,
// a response scoreboard and direct checks of the memory-side outputs.
module tb_dmem_access_ctrl;
   import dmem_access_ctrl_pkg::*;

   localparam int TO    = 16;
   localparam int NEVER = 999;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rdata;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_is_store(is_store), .iv_funct3(funct3), .iv_addr(addr), .iv_wdata(wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .ov_rdata(rdata),
      .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .ov_mem_addr(mem_addr),
      .o_mem_we(mem_we), .ov_mem_be(mem_be), .ov_mem_wdata(mem_wdata),
      .i_mem_rvalid(mem_rvalid), .iv_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          vec_cnt = 0;
   int          miscmp_cnt = 0;

   bit          hold_nxt = 1'b0;
   logic        nx_store;
   logic [2:0]  nx_f3;
   logic [31:0] nx_addr, nx_wdata;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic err, input logic [31:0] rd, input int lat);
      exp_t e;
      e.err = err; e.rdata = rd; e.lat = lat;
      sb_q.push_back(e);
   endtask

   task automatic drive_req(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
   endtask

   // Runs the memory side from the cycle after acceptance until the response.
   task automatic service(input string tag, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd, input bit spur,
                          input logic [31:0] exp_addr, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int   c = 0;
      int   k = 0;
      int   w = 0;
      bit   granted = 1'b0;
      bit   done = 1'b0;
      exp_t e;
      while (!done && c < 60) begin
         @(negedge clk);
         c++;
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (c == 1) begin
            if (hold_nxt) begin
               drive_req(nx_store, nx_f3, nx_addr, nx_wdata);
               hold_nxt = 1'b0;
            end else begin
               req_valid = 1'b0;
            end
         end
         check_val({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
         if (rsp_valid) begin
            done = 1'b1;
            check_val({tag, "_mem_req_at_rsp"}, 32'(mem_req), 32'd0);
            if (sb_q.size() == 0) begin
               check_val({tag, "_sb_empty"}, 32'(rsp_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_val({tag, "_err"}, 32'(rsp_err), 32'(e.err));
               check_val({tag, "_rdata"}, rdata, e.rdata);
               check_val({tag, "_lat"}, 32'(c), 32'(e.lat));
            end
         end else if (mem_req) begin
            check_val({tag, "_addr"}, mem_addr, exp_addr);
            check_val({tag, "_we"}, 32'(mem_we), 32'(exp_we));
            check_val({tag, "_be"}, 32'(mem_be), 32'(exp_be));
            if (exp_we) check_val({tag, "_wdata"}, mem_wdata, exp_wd);
            if (spur) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 32'hDEADBEEF;
            end
            if (k == gnt_dly) begin
               mem_gnt = 1'b1;
               granted = 1'b1;
            end
            k++;
         end else if (granted) begin
            if (w == rv_dly) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd;
            end
            w++;
         end else begin
            check_val({tag, "_mem_req_missing"}, 32'(mem_req), 32'd1);
         end
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!done) check_val({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
   endtask

   task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input int gnt_dly, input int rv_dly, input bit spur,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic exp_err,
                      input logic [31:0] exp_rd, input int exp_lat);
      @(negedge clk);
      check_val({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      drive_req(st, f3, a, wd);
      push_exp(exp_err, exp_rd, exp_lat);
      service(tag, gnt_dly, rv_dly, rd, spur, exp_addr, st, exp_be, exp_wd);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ready"}, 32'(req_ready), 32'd0);
      check_val({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check_val({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check_val({tag, "_rdata"}, rdata, 32'd0);
      check_val({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_val({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check_val({tag, "_mem_be"}, 32'(mem_be), 32'd0);
      check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      nx_store = 1'b0; nx_f3 = 3'b000; nx_addr = '0; nx_wdata = '0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);

      // Stores: lane replication and byte enables
      txn("sb",     1, F3_B, 32'h0000_1003, 32'h0000_00A5, 0, 0, NEVER, 0,
          32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0, 2);
      txn("sh_hi",  1, F3_H, 32'h0000_2002, 32'h0000_BEEF, 0, 0, NEVER, 0,
          32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 2);
      txn("sh_lo",  1, F3_H, 32'h0000_2000, 32'h1234_CAFE, 0, 0, NEVER, 0,
          32'h0000_2000, 4'b0011, 32'hCAFE_CAFE, 0, 32'h0, 2);

      // Loads: lane select and extension
      txn("lb",     0, F3_B,  32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 0,
          32'h0000_2000, 4'b1111, 32'h0, 0, 32'hFFFF_FF80, 3);
      txn("lbu",    0, F3_BU, 32'h0000_2001, 32'h0, 32'h1234_8056, 0, 0, 0,
          32'h0000_2000, 4'b1111, 32'h0, 0, 32'h0000_0080, 3);
      txn("lhu",    0, F3_HU, 32'h0000_2002, 32'h0, 32'h1234_8056, 0, 0, 0,
          32'h0000_2000, 4'b1111, 32'h0, 0, 32'h0000_1234, 3);
      txn("lh",     0, F3_H,  32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 0,
          32'h0000_2000, 4'b1111, 32'h0, 0, 32'hFFFF_8001, 3);
      txn("lb_pos", 0, F3_B,  32'h0000_2003, 32'h0, 32'h7F00_0000, 0, 0, 0,
          32'h0000_2000, 4'b1111, 32'h0, 0, 32'h0000_007F, 3);

      // Misaligned and illegal funct3: no memory access, error at cycle 1
      txn("lw_mis",  0, F3_W,   32'h0000_3002, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);
      txn("st_f3_3", 1, 3'b011, 32'h0000_3000, 32'h5, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);
      txn("ld_f3_6", 0, 3'b110, 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);
      txn("lh_mis",  0, F3_H,   32'h0000_2001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);
      txn("sh_mis",  1, F3_H,   32'h0000_2003, 32'h7, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);
      txn("sbu_bad", 1, F3_BU,  32'h0000_2000, 32'h7, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1);

      // Wait states and timeouts
      txn("sw_gnt5",  1, F3_W, 32'h0000_0050, 32'h1234_5678, 0, 5, NEVER, 0,
          32'h0000_0050, 4'b1111, 32'h1234_5678, 0, 32'h0, 7);
      txn("sw_to",    1, F3_W, 32'h0000_0060, 32'hCAFE_BABE, 0, NEVER, NEVER, 0,
          32'h0000_0060, 4'b1111, 32'hCAFE_BABE, 1, 32'h0, TO + 1);
      txn("sw_gnt_last", 1, F3_W, 32'h0000_0064, 32'h0BAD_F00D, 0, TO - 1, NEVER, 0,
          32'h0000_0064, 4'b1111, 32'h0BAD_F00D, 0, 32'h0, TO + 1);
      txn("lw_wait",  0, F3_W, 32'h0000_0070, 32'h0, 32'h5566_7788, 2, 3, 1,
          32'h0000_0070, 4'b1111, 32'h0, 0, 32'h5566_7788, 8);
      txn("lw_rv_to", 0, F3_W, 32'h0000_0074, 32'h0, 32'h0, 0, NEVER, 0,
          32'h0000_0074, 4'b1111, 32'h0, 1, 32'h0, TO + 2);
      txn("lw_rv_last", 0, F3_W, 32'h0000_0078, 32'h0, 32'h0102_0304, 0, TO - 1, 0,
          32'h0000_0078, 4'b1111, 32'h0, 0, 32'h0102_0304, TO + 2);

      // Asynchronous reset while the request is on the bus
      @(negedge clk);
      drive_req(1, F3_W, 32'h0000_0080, 32'h1111_2222);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("rst_req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_in_req");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in WAIT_R, then a late rvalid that must be ignored
      @(negedge clk);
      drive_req(0, F3_W, 32'h0000_3000, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      check_val("rst_wait_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check_val("rst_wait_noreq", 32'(mem_req), 32'd0);
      check_val("rst_wait_norsp", 32'(rsp_valid), 32'd0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_in_wait");
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check_val("late_rv_rsp0", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check_val("late_rv_rsp1", 32'(rsp_valid), 32'd0);
      check_val("late_rv_ready", 32'(req_ready), 32'd1);
      txn("lw_after_rst", 0, F3_W, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0, 0, 0,
          32'h0000_4000, 4'b1111, 32'h0, 0, 32'hCAFE_F00D, 3);

      // Back-to-back: valid held high, second request waits for IDLE
      @(negedge clk);
      check_val("b2b_ready_a", 32'(req_ready), 32'd1);
      drive_req(1, F3_W, 32'h0000_0010, 32'h1111_1111);
      push_exp(0, 32'h0, 2);
      hold_nxt = 1'b1;
      nx_store = 1'b1; nx_f3 = F3_B; nx_addr = 32'h0000_0021; nx_wdata = 32'h0000_007F;
      service("b2b_a", 0, NEVER, 32'h0, 0, 32'h0000_0010, 1, 4'b1111, 32'h1111_1111);
      @(negedge clk);
      check_val("b2b_ready_b", 32'(req_ready), 32'd1);
      check_val("b2b_idle_noreq", 32'(mem_req), 32'd0);
      push_exp(0, 32'h0, 2);
      service("b2b_b", 0, NEVER, 32'h0, 0, 32'h0000_0020, 1, 4'b0010, 32'h7F7F_7F7F);
      @(negedge clk);
      check_val("b2b_done_ready", 32'(req_ready), 32'd1);
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
